random_ca_stream: RTL and testbench
===================================

Name: random_ca_stream

Overview:
- Parametrised successor to the team's cellular-automaton random source.
- Runs a WIDTH-cell 1D elementary CA whose rule rotates through 30/60/90/150 under a data-dependent counter, with a rotate-XOR whitener on the output.
- Adds a seed load/reseed handshake, a configurable warm-up phase and a valid/ready output stream.
- Feeds genetic-operator blocks (mutation/crossover masks) that consume random words with backpressure.

Parameters:
- WIDTH, 8, CA cell count and output word width (>=3).
- WARMUP, 16, CA steps discarded after each seed load (0 allowed).
- CNT_W, 6, rule-schedule counter width (>=2); rule select is counter[CNT_W-1:CNT_W-2].

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- seed_valid  in  1  seed offered
- seed_ready  out  1  seed accepted when high together with seed_valid
- seed  in  WIDTH  seed value
- out_valid  out  1  out_data holds a fresh word
- out_ready  in  1  consumer takes word
- out_data  out  WIDTH  random word
- warming  out  1  high while in WARMUP

Behaviour:
- Reset values: ca=1 (bit0 set), whitener acc=0, counter=0, warm count=0, state=IDLE, out_valid=0, out_data=0, seed_ready=1, warming=0.
- FSM states:
  - IDLE: seed_ready=1; nothing steps.
  - WARMUP: seed_ready=0, warming=1.
  - RUN: seed_ready=1, warming=0.
- Seed accept (seed_valid && seed_ready, IDLE or RUN):
  - ca <= seed, or 1 if seed==0, since all four rules are zero-preserving.
  - acc <= 0, counter <= 0, out_valid <= 0; any pending word is dropped.
  - Go to WARMUP with warm count=WARMUP, or straight to RUN if WARMUP=0.
- CA step, using cells before the step:
  - next[i] = rule[{c[(i+1)%W], c[i], c[(i-1+W)%W]}]. Index 0 wraps to W-1 and index W-1 wraps to 0.
  - rule by counter top 2 bits: 00 -> 8'h1E, 01 -> 8'h3C, 10 -> 8'h5A, 11 -> 8'h96.
  - Same edge: acc <= rotl(acc,1) ^ next; counter <= counter + 1 + ^next, mod 2^CNT_W (wrap, no saturation).
- WARMUP: one step per cycle, warm count decrements; when it reaches 0 after a step, go to RUN. No output is produced.
- RUN:
  - A step occurs when !out_valid || out_ready. On a step, out_data <= new acc and out_valid <= 1.
  - When out_valid && !out_ready, nothing steps and out_data/out_valid hold (stable under backpressure).
- Latency and throughput:
  - Seed accepted at edge k: warm steps at edges k+1..k+WARMUP; first out_valid rises after edge k+WARMUP+1.
  - Throughput is 1 word/cycle with out_ready held high.
- Simultaneous reseed and out_ready in RUN: the reseed wins, out_valid drops next cycle, and no step is taken.
- Reset mid-WARMUP or mid-RUN returns to the reset values immediately (asynchronous).
- IDLE is left only via a seed accept; there is no autonomous output before the first seed.

Optional Feature:
- Macro RANDOM_CA_STREAM_HEALTH_EN.
- Defined:
  - Adds output health_err (1 bit, reset 0).
  - Cycle check: if a step produces next == ca (fixed point), health_err pulses for 1 cycle and ca is forced to {ca[WIDTH-1:1], ~ca[0]} in place of next.
  - acc/counter update with the forced value.
- Undefined: the port and logic are absent; fixed points persist.

Test Plan:
- Reset: assert rst mid-stream -> out_valid=0, out_data=0, seed_ready=1, warming=0 the same cycle.
- Known sequence (WIDTH=8, WARMUP=0): seed 8'h01 -> words 8'h83, then 8'h41, with out_ready=1.
- Warm-up timing (WARMUP=16): seed accepted at edge k -> warming high for 16 cycles, seed_ready=0 throughout, out_valid first high after edge k+17.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable. Release -> next word equals the no-stall sequence (no words lost or skipped).
- Zero seed / reseed: seed 8'h00 -> same stream as seed 8'h01. Reseed in RUN with out_ready=1 on the same cycle -> out_valid=0 next cycle, stream restarts from the new seed.
- Health (macro on, WIDTH=8, WARMUP=0): seed 8'hFF, rule 30 step gives 8'h00 -> no err. Force a fixed point (rule 60 on 8'h00 via internal seed) -> health_err 1-cycle pulse and cell0 flipped.

Source files
------------

// File: rtl/random_ca_stream.sv
`default_nettype none
// ============================================================================
// Module   : random_ca_stream
// Purpose  : WIDTH-cell elementary CA (rules 30/60/90/150) with a rotate-XOR
//            whitener, seed handshake, warm-up phase and valid/ready output.
//            Optional fixed-point health check: RANDOM_CA_STREAM_HEALTH_EN
// Revision : 1.0 - initial release
// ============================================================================
module random_ca_stream #(
  parameter int WIDTH  = 8,
  parameter int WARMUP = 16,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [WIDTH-1:0] seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             warming
`ifdef RANDOM_CA_STREAM_HEALTH_EN
  ,
  output logic             health_err
`endif
);

  localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_ca;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic [WARM_W-1:0] r_warm;
  logic [7:0]        w_rule;
  logic [WIDTH-1:0]  w_next;
  logic [WIDTH-1:0]  w_step_val;
  logic [WIDTH-1:0]  w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_seed_acc;
  logic              w_step;

  // Rule schedule driven by the top two bits of the data-dependent counter
  always_comb begin
    case (r_cnt[CNT_W-1 -: 2])
      2'b00:   w_rule = 8'h1E;
      2'b01:   w_rule = 8'h3C;
      2'b10:   w_rule = 8'h5A;
      default: w_rule = 8'h96;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_next[i] = w_rule[{r_ca[(i + 1) % WIDTH], r_ca[i], r_ca[(i + WIDTH - 1) % WIDTH]}];
  end

`ifdef RANDOM_CA_STREAM_HEALTH_EN
  logic w_fixed;
  logic r_health_err;
  // A fixed point would lock the CA forever; kick it out by flipping cell 0
  assign w_fixed    = (w_next == r_ca);
  assign w_step_val = w_fixed ? {r_ca[WIDTH-1:1], ~r_ca[0]} : w_next;
  assign health_err = r_health_err;
`else
  assign w_step_val = w_next;
`endif

  assign w_acc_nxt = {r_acc[WIDTH-2:0], r_acc[WIDTH-1]} ^ w_step_val;
  assign w_cnt_nxt = r_cnt + CNT_W'(1) + CNT_W'(^w_step_val);

  assign seed_ready = (r_state != S_WARMUP);
  assign warming    = (r_state == S_WARMUP);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign w_seed_acc = seed_valid && seed_ready;
  assign w_step     = !w_seed_acc &&
                      ((r_state == S_WARMUP) ||
                       ((r_state == S_RUN) && (!r_out_valid || out_ready)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WARMUP: if (r_warm <= WARM_W'(1)) w_state_nxt = S_RUN;
      default:  if (w_seed_acc) w_state_nxt = (WARMUP == 0) ? S_RUN : S_WARMUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ca        <= WIDTH'(1);
      r_acc       <= '0;
      r_cnt       <= '0;
      r_warm      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef RANDOM_CA_STREAM_HEALTH_EN
      r_health_err <= 1'b0;
`endif
    end else begin
`ifdef RANDOM_CA_STREAM_HEALTH_EN
      r_health_err <= 1'b0;
`endif
      if (w_seed_acc) begin
        // All rules map all-zero to all-zero, so a zero seed would stall
        r_ca        <= (seed == '0) ? WIDTH'(1) : seed;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_warm      <= WARM_W'(WARMUP);
        r_out_valid <= 1'b0;
      end else if (w_step) begin
        r_ca  <= w_step_val;
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
`ifdef RANDOM_CA_STREAM_HEALTH_EN
        r_health_err <= w_fixed;
`endif
        if (r_state == S_WARMUP) begin
          r_warm <= r_warm - WARM_W'(1);
        end else begin
          r_out_data  <= w_acc_nxt;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_random_ca_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_random_ca_stream
// Purpose  : Directed checks of random_ca_stream (WARMUP=0 and WARMUP=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_random_ca_stream;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         sv_a = 1'b0, or_a = 1'b1;
  logic [W-1:0] seed_a = '0;
  logic         sr_a, ov_a, warm_a;
  logic [W-1:0] od_a;

  logic         sv_b = 1'b0, or_b = 1'b1;
  logic [W-1:0] seed_b = '0;
  logic         sr_b, ov_b, warm_b;
  logic [W-1:0] od_b;

`ifdef RANDOM_CA_STREAM_HEALTH_EN
  logic         hz_a, hz_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_s [5] = '{8'h83, 8'h41, 8'h6F, 8'hD7, 8'h30};

  random_ca_stream #(.WIDTH(W), .WARMUP(0), .CNT_W(6)) u_dut_a (
    .clk(clk), .rst(rst),
    .seed_valid(sv_a), .seed_ready(sr_a), .seed(seed_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .warming(warm_a)
`ifdef RANDOM_CA_STREAM_HEALTH_EN
    , .health_err(hz_a)
`endif
  );

  random_ca_stream #(.WIDTH(W), .WARMUP(16), .CNT_W(6)) u_dut_b (
    .clk(clk), .rst(rst),
    .seed_valid(sv_b), .seed_ready(sr_b), .seed(seed_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .warming(warm_b)
`ifdef RANDOM_CA_STREAM_HEALTH_EN
    , .health_err(hz_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_ov_a",   ov_a,   0);
    check_eq("rst_od_a",   od_a,   0);
    check_eq("rst_sr_a",   sr_a,   1);
    check_eq("rst_warm_a", warm_a, 0);
    check_eq("rst_ov_b",   ov_b,   0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_no_out_b", ov_b, 0);

    // Known sequence from seed 01 with backpressure in the middle
    sv_a = 1'b1; seed_a = 8'h01;
    @(negedge clk); sv_a = 1'b0;
    check_eq("seed_no_word", ov_a, 0);
    @(negedge clk);
    check_eq("w0_valid", ov_a, 1);
    check_eq("w0", od_a, exp_s[0]);
    @(negedge clk);
    check_eq("w1", od_a, exp_s[1]);
    or_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_data", od_a, exp_s[1]);
      check_eq("stall_valid", ov_a, 1);
    end
    or_a = 1'b1;
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      check_eq("after_stall", od_a, exp_s[i]);
    end

    // Zero seed while a word is being taken: reseed wins
    sv_a = 1'b1; seed_a = 8'h00;
    @(negedge clk); sv_a = 1'b0;
    check_eq("reseed_drop", ov_a, 0);
    @(negedge clk);
    check_eq("z_w0", od_a, exp_s[0]);
    check_eq("z_w0_valid", ov_a, 1);
    @(negedge clk);
    check_eq("z_w1", od_a, exp_s[1]);

    // Seed FF: rule 30 gives all-zero, which is then a fixed point
    sv_a = 1'b1; seed_a = 8'hFF;
    @(negedge clk); sv_a = 1'b0;
    check_eq("ff_drop", ov_a, 0);
    @(negedge clk);
    check_eq("ff_w0", od_a, 8'h00);
    check_eq("ff_w0_valid", ov_a, 1);
`ifdef RANDOM_CA_STREAM_HEALTH_EN
    check_eq("ff_h0", hz_a, 0);
    @(negedge clk);
    check_eq("ff_w1", od_a, 8'h01);
    check_eq("ff_h1", hz_a, 1);
    @(negedge clk);
    check_eq("ff_w2", od_a, 8'h81);
    check_eq("ff_h2", hz_a, 0);
`else
    @(negedge clk);
    check_eq("ff_w1", od_a, 8'h00);
    @(negedge clk);
    check_eq("ff_w2", od_a, 8'h00);
`endif

    // Warm-up timing on the WARMUP=16 instance
    sv_b = 1'b1; seed_b = 8'h01;
    @(negedge clk); sv_b = 1'b0;
    for (int j = 0; j < 16; j++) begin
      check_eq("wu_warming", warm_b, 1);
      check_eq("wu_sready", sr_b, 0);
      check_eq("wu_no_out", ov_b, 0);
      @(negedge clk);
    end
    check_eq("wu_done_warming", warm_b, 0);
    check_eq("wu_done_sready", sr_b, 1);
    check_eq("wu_done_no_out", ov_b, 0);
    @(negedge clk);
    check_eq("wu_first_valid", ov_b, 1);

    // Asynchronous reset with A streaming and B mid-warm-up
    sv_a = 1'b1; seed_a = 8'h01;
    sv_b = 1'b1; seed_b = 8'h5A;
    @(negedge clk); sv_a = 1'b0; sv_b = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_od_a", od_a, exp_s[0]);
    check_eq("pre_rst_warm_b", warm_b, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ov_a", ov_a, 0);
    check_eq("arst_od_a", od_a, 0);
    check_eq("arst_sr_a", sr_a, 1);
    check_eq("arst_warm_a", warm_a, 0);
    check_eq("arst_warm_b", warm_b, 0);
    check_eq("arst_sr_b", sr_b, 1);
    check_eq("arst_ov_b", ov_b, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_idle_a", ov_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
